host_stream_checker: RTL and testbench
======================================

Name: host_stream_checker

Overview:
- Receive-side counterpart of the host perf traffic source: sinks the host→card stream and checks it against a deterministic incrementing pattern.
- Counts beats, errors and elapsed cycles; all configuration and results go through an AXI4-Lite register file.
- Instantiated inside a user_logic region: axi_ctrl on the vFPGA control port, axis_host_sink on the host sink stream.

Parameters:
- DATA_BITS, 512, stream data width; must be a multiple of 64.
- CNT_BITS, 32, width of the beat, error and cycle counters.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- axi_ctrl  AXI4L.s  64-bit data  control/status register slave.
- s_tvalid  in  1  sink stream valid.
- s_tready  out  1  sink stream ready.
- s_tdata  in  DATA_BITS  sink data.
- s_tkeep  in  DATA_BITS/8  sink byte enables.
- s_tlast  in  1  end of packet.
- s_tid  in  6  PID; captured, not checked.

Behaviour:
- Register map (8-byte stride). Writes complete with BRESP=OKAY one cycle after both AW and W handshakes. Reads return RDATA/RRESP=OKAY one cycle after the AR handshake. One outstanding transaction per channel. Unmapped reads return 0.
  - 0x00 CTRL (W): bit0 = start (pulse); bit1 = clear counters (pulse, IDLE/DONE only).
  - 0x08 STATUS (R): bit0 busy, bit1 done, bit2 err (err_cnt != 0).
  - 0x10 EXP_BEATS (RW).
  - 0x18 SEED (RW).
  - 0x20 RX_BEATS (R).
  - 0x28 ERR_CNT (R).
  - 0x30 CYCLES (R).
  - 0x38 FIRST_ERR (R): beat index of the first error; all-ones if none.
  - 0x40 LAST_TID (R).
- Expected data: for beat i, 64-bit lane j = SEED + i*(DATA_BITS/64) + j, mod 2^64.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start. Counters and FIRST_ERR are cleared and the beat index is set to 0.
  - If EXP_BEATS == 0, start goes IDLE→DONE directly with no error.
  - RUN→DONE on the accepted beat with index EXP_BEATS-1, or on any accepted beat with tlast=1.
  - DONE→RUN on a new start. Any state→IDLE on reset.
  - start while in RUN is ignored.
- s_tready = 1 only in RUN. It is combinational from state and does not depend on s_tvalid.
- A beat is accepted when s_tvalid && s_tready. Per accepted beat:
  - RX_BEATS increments.
  - LAST_TID takes s_tid.
  - ERR_CNT increments by at most 1 per beat if any of these hold:
    - a data lane mismatches;
    - s_tkeep is not all-ones;
    - tlast is set on a beat other than EXP_BEATS-1;
    - tlast is clear on beat EXP_BEATS-1.
  - FIRST_ERR latches the index of the first errored beat.
- CYCLES increments every cycle in RUN, including the cycle of the final beat. It does not count in IDLE or DONE.
- All counters saturate at 2^CNT_BITS-1 and never wrap.
- busy = (state == RUN); done = (state == DONE).
- Reset values: s_tready=0, all AXI valid outputs 0, every register and counter 0, FIRST_ERR all-ones, state IDLE.
- Reset asserted mid-packet drops the check immediately. No response is pending after reset.
- A CTRL write with start=1 and clear=1 together acts as start.
- A register write to EXP_BEATS or SEED during RUN takes effect only at the next start.

Test Plan:
- Clean packet: SEED=0x100, EXP_BEATS=4, four correct beats with tlast on beat 3 → RX_BEATS=4, ERR_CNT=0, FIRST_ERR=all-ones, STATUS=0b010, CYCLES ≥ 4.
- Corrupt data: SEED=0, EXP_BEATS=8, lane 3 of beat 5 flipped → ERR_CNT=1, FIRST_ERR=5, STATUS.err=1, RX_BEATS=8.
- Early tlast: EXP_BEATS=10, tlast on beat 6 → DONE after 7 beats, ERR_CNT=1, FIRST_ERR=6, s_tready=0 on the following cycle.
- Backpressure and gaps: random s_tvalid gaps with EXP_BEATS=16 → no errors, RX_BEATS=16, CYCLES equals the cycle count from start to the final beat.
- Zero length and restart: EXP_BEATS=0 start → done=1 immediately, s_tready never 1. A second start while in RUN is ignored. Start from DONE clears all counters.
- Reset mid-run: assert areset after beat 2 of 8 → s_tready=0 within the same cycle, all registers read back reset values, FIRST_ERR=all-ones.

Source files
------------

// File: rtl/host_stream_checker_if.sv
// AXI4-Lite control port (8-bit address, 64-bit data) for host_stream_checker.
// AW and W are expected to be presented together; the slave accepts them in one cycle.
interface host_stream_checker_if;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/host_stream_checker.sv
// Sinks the host->card stream and checks it against an incrementing 64-bit lane pattern.
// Beat, error and cycle counters plus configuration are exposed over AXI4-Lite.
module host_stream_checker #(
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned CNT_BITS  = 32
) (
  input  logic                   aclk,
  input  logic                   areset,
  host_stream_checker_if.slave   axi_ctrl,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_BITS-1:0]   s_tdata,
  input  logic [DATA_BITS/8-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [5:0]             s_tid
);
  localparam int unsigned Lanes = DATA_BITS / 64;
  localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
  state_e r_state, w_state_d;

  logic [CNT_BITS-1:0] r_exp_beats, r_exp_run, r_rx_beats, r_err_cnt, r_cycles, r_first_err;
  logic [63:0]         r_seed, r_base, r_rdata;
  logic [5:0]          r_last_tid;
  logic                r_bvalid, r_rvalid;

  logic        w_wr_fire, w_rd_fire, w_ctrl_wr, w_start, w_clear, w_load, w_clr;
  logic        w_beat, w_last_exp, w_data_ok, w_beat_err;
  logic [63:0] w_wmask, w_rd_data;

  // AW and W are taken in the same cycle so a single edge commits the write and raises BVALID.
  assign w_wr_fire        = axi_ctrl.awvalid && axi_ctrl.wvalid && !r_bvalid;
  assign axi_ctrl.awready = w_wr_fire;
  assign axi_ctrl.wready  = w_wr_fire;
  assign axi_ctrl.bvalid  = r_bvalid;
  assign axi_ctrl.bresp   = 2'b00;
  assign w_rd_fire        = axi_ctrl.arvalid && !r_rvalid;
  assign axi_ctrl.arready = !r_rvalid;
  assign axi_ctrl.rvalid  = r_rvalid;
  assign axi_ctrl.rdata   = r_rdata;
  assign axi_ctrl.rresp   = 2'b00;

  assign w_ctrl_wr = w_wr_fire && (axi_ctrl.awaddr == 8'h00);
  assign w_start   = w_ctrl_wr && axi_ctrl.wdata[0];
  assign w_clear   = w_ctrl_wr && axi_ctrl.wdata[1] && (r_state != StRun);
  assign w_load    = w_start && (r_state != StRun);
  assign w_clr     = w_load || w_clear;

  assign s_tready   = (r_state == StRun);
  assign w_beat     = s_tvalid && s_tready;
  assign w_last_exp = (r_rx_beats == r_exp_run - CntOne);
  // tlast must be set exactly on the expected final beat.
  assign w_beat_err = !w_data_ok || !(&s_tkeep) || (s_tlast != w_last_exp);

  always_comb begin
    w_data_ok = 1'b1;
    for (int unsigned j = 0; j < Lanes; j++) begin
      if (s_tdata[64*j +: 64] != r_base + 64'(j)) w_data_ok = 1'b0;
    end
  end

  always_comb begin
    w_wmask = '0;
    for (int unsigned b = 0; b < 8; b++) w_wmask[8*b +: 8] = {8{axi_ctrl.wstrb[b]}};
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: if (w_start) w_state_d = (r_exp_beats == '0) ? StDone : StRun;
      StRun:          if (w_beat && (w_last_exp || s_tlast)) w_state_d = StDone;
      default:        w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_exp_beats <= '0;
      r_seed      <= '0;
    end else if (w_wr_fire) begin
      case (axi_ctrl.awaddr)
        8'h10: r_exp_beats <= CNT_BITS'((64'(r_exp_beats) & ~w_wmask) |
                                        (axi_ctrl.wdata & w_wmask));
        8'h18: r_seed      <= (r_seed & ~w_wmask) | (axi_ctrl.wdata & w_wmask);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (axi_ctrl.araddr)
      8'h08: w_rd_data = {61'd0, (r_err_cnt != '0), (r_state == StDone), (r_state == StRun)};
      8'h10: w_rd_data = 64'(r_exp_beats);
      8'h18: w_rd_data = r_seed;
      8'h20: w_rd_data = 64'(r_rx_beats);
      8'h28: w_rd_data = 64'(r_err_cnt);
      8'h30: w_rd_data = 64'(r_cycles);
      8'h38: w_rd_data = 64'(r_first_err);
      8'h40: w_rd_data = 64'(r_last_tid);
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_fire)            r_bvalid <= 1'b1;
      else if (axi_ctrl.bready) r_bvalid <= 1'b0;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (axi_ctrl.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // EXP_BEATS and SEED are snapshotted at start so mid-run writes only affect the next run.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_exp_run   <= '0;
      r_base      <= '0;
      r_rx_beats  <= '0;
      r_err_cnt   <= '0;
      r_cycles    <= '0;
      r_first_err <= '1;
      r_last_tid  <= '0;
    end else begin
      if (w_load) begin
        r_exp_run <= r_exp_beats;
        r_base    <= r_seed;
      end
      if (w_clr) begin
        r_rx_beats  <= '0;
        r_err_cnt   <= '0;
        r_cycles    <= '0;
        r_first_err <= '1;
      end else if (r_state == StRun) begin
        if (r_cycles != CntMax) r_cycles <= r_cycles + CntOne;
        if (w_beat) begin
          if (r_rx_beats != CntMax) r_rx_beats <= r_rx_beats + CntOne;
          r_last_tid <= s_tid;
          r_base     <= r_base + 64'(Lanes);
          if (w_beat_err) begin
            if (r_err_cnt != CntMax) r_err_cnt <= r_err_cnt + CntOne;
            if (r_err_cnt == '0)     r_first_err <= r_rx_beats;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_host_stream_checker.sv
// Self-checking bench for host_stream_checker: drives packets, reads registers through AXI-Lite
// and compares readback against a queue of expected values.
module tb_host_stream_checker;
  localparam int unsigned DataBits = 256;
  localparam int unsigned Lanes    = DataBits / 64;
  localparam int unsigned CntBits  = 32;
  localparam logic [63:0] NoErr    = 64'h0000_0000_FFFF_FFFF;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic                  s_tvalid, s_tready, s_tlast;
  logic [DataBits-1:0]   s_tdata;
  logic [DataBits/8-1:0] s_tkeep;
  logic [5:0]            s_tid;

  host_stream_checker_if axi_ctrl();

  host_stream_checker #(.DATA_BITS(DataBits), .CNT_BITS(CntBits)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .axi_ctrl (axi_ctrl),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tid    (s_tid)
  );

  always #5 aclk = ~aclk;

  int unsigned     n_checks = 0;
  int unsigned     n_errors = 0;
  longint unsigned cyc = 0;
  longint unsigned t_start, t_last, ts;
  logic [63:0]     exp_q[$];
  string           tag_q[$];
  logic [63:0]     seed;

  logic [7:0]  rst_addr[9] = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'h40, 8'h48};
  logic [63:0] rst_val[9]  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, NoErr, 64'd0, 64'd0};

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [63:0] d);
    int n = 0;
    @(negedge aclk);
    axi_ctrl.awaddr  = a;
    axi_ctrl.wdata   = d;
    axi_ctrl.wstrb   = 8'hFF;
    axi_ctrl.awvalid = 1'b1;
    axi_ctrl.wvalid  = 1'b1;
    axi_ctrl.bready  = 1'b1;
    #1;
    while (!axi_ctrl.awready && n < 20) begin @(negedge aclk); #1; n++; end
    if (!axi_ctrl.awready) check_eq("awready", 64'(axi_ctrl.awready), 64'd1);
    @(posedge aclk); #1;
    t_start = cyc;
    axi_ctrl.awvalid = 1'b0;
    axi_ctrl.wvalid  = 1'b0;
    n = 0;
    while (!axi_ctrl.bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    check_eq("bvalid", 64'(axi_ctrl.bvalid), 64'd1);
    @(posedge aclk); #1;
    axi_ctrl.bready = 1'b0;
  endtask

  // Expected value is queued when the read is issued and popped when RVALID arrives.
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [63:0] e);
    int n = 0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge aclk);
    axi_ctrl.araddr  = a;
    axi_ctrl.arvalid = 1'b1;
    axi_ctrl.rready  = 1'b1;
    #1;
    while (!axi_ctrl.arready && n < 20) begin @(negedge aclk); #1; n++; end
    @(posedge aclk); #1;
    axi_ctrl.arvalid = 1'b0;
    n = 0;
    while (!axi_ctrl.rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!axi_ctrl.rvalid) check_eq({tag, "_rvalid"}, 64'(axi_ctrl.rvalid), 64'd1);
    check_eq(tag_q.pop_front(), axi_ctrl.rdata, exp_q.pop_front());
    @(posedge aclk); #1;
    axi_ctrl.rready = 1'b0;
  endtask

  function automatic logic [DataBits-1:0] mk_beat(input logic [63:0] sd, input int idx);
    logic [DataBits-1:0] d;
    for (int j = 0; j < Lanes; j++) d[64*j +: 64] = sd + 64'(idx) * Lanes + 64'(j);
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] sd, input int idx, input bit last, input int gap,
                           input logic [DataBits/8-1:0] keep, input int flip_lane);
    int n = 0;
    logic [DataBits-1:0] d;
    d = mk_beat(sd, idx);
    if (flip_lane >= 0) d[64*flip_lane +: 64] = d[64*flip_lane +: 64] ^ 64'h1;
    repeat (gap) @(posedge aclk);
    @(negedge aclk);
    s_tdata  = d;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tid    = 6'(idx);
    s_tvalid = 1'b1;
    #1;
    while (!s_tready && n < 20) begin @(negedge aclk); #1; n++; end
    if (!s_tready) check_eq("tready_wait", 64'(s_tready), 64'd1);
    @(posedge aclk); #1;
    t_last   = cyc;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic check_reset_regs(input string pfx);
    for (int i = 0; i < 9; i++)
      rd_chk($sformatf("%s_reg%0h", pfx, rst_addr[i]), rst_addr[i], rst_val[i]);
  endtask

  initial begin
    bit seen;
    axi_ctrl.awaddr = '0; axi_ctrl.awvalid = 0; axi_ctrl.wdata = '0; axi_ctrl.wstrb = '0;
    axi_ctrl.wvalid = 0;  axi_ctrl.bready = 0;  axi_ctrl.araddr = '0; axi_ctrl.arvalid = 0;
    axi_ctrl.rready = 0;
    s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tlast = 0; s_tid = '0;
    repeat (3) @(posedge aclk);
    @(negedge aclk) areset = 1'b0;
    #1;
    check_eq("rst_tready", 64'(s_tready), 64'd0);
    check_eq("rst_bvalid", 64'(axi_ctrl.bvalid), 64'd0);
    check_eq("rst_rvalid", 64'(axi_ctrl.rvalid), 64'd0);
    check_reset_regs("rst");

    // Clean packet
    axi_write(8'h18, 64'h100);
    axi_write(8'h10, 64'd4);
    axi_write(8'h00, 64'd1);
    ts = t_start;
    for (int i = 0; i < 4; i++) send_beat(64'h100, i, i == 3, 0, '1, -1);
    rd_chk("clean_rx", 8'h20, 64'd4);
    rd_chk("clean_err", 8'h28, 64'd0);
    rd_chk("clean_first", 8'h38, NoErr);
    rd_chk("clean_status", 8'h08, 64'b010);
    rd_chk("clean_cycles", 8'h30, 64'(t_last - ts));
    rd_chk("clean_tid", 8'h40, 64'd3);

    // Corrupt lane 3 of beat 5
    axi_write(8'h18, 64'd0);
    axi_write(8'h10, 64'd8);
    axi_write(8'h00, 64'd1);
    for (int i = 0; i < 8; i++) send_beat(64'd0, i, i == 7, 0, '1, (i == 5) ? 3 : -1);
    rd_chk("corrupt_rx", 8'h20, 64'd8);
    rd_chk("corrupt_err", 8'h28, 64'd1);
    rd_chk("corrupt_first", 8'h38, 64'd5);
    rd_chk("corrupt_status", 8'h08, 64'b110);

    // Early tlast on beat 6 of 10
    axi_write(8'h10, 64'd10);
    axi_write(8'h00, 64'd1);
    for (int i = 0; i < 7; i++) send_beat(64'd0, i, i == 6, 0, '1, -1);
    @(negedge aclk);
    check_eq("early_tready", 64'(s_tready), 64'd0);
    rd_chk("early_status", 8'h08, 64'b110);
    rd_chk("early_rx", 8'h20, 64'd7);
    rd_chk("early_err", 8'h28, 64'd1);
    rd_chk("early_first", 8'h38, 64'd6);

    // Random gaps
    seed = {$urandom, $urandom};
    axi_write(8'h18, seed);
    axi_write(8'h10, 64'd16);
    axi_write(8'h00, 64'd1);
    ts = t_start;
    for (int i = 0; i < 16; i++) send_beat(seed, i, i == 15, int'($urandom_range(0, 3)), '1, -1);
    rd_chk("gap_err", 8'h28, 64'd0);
    rd_chk("gap_rx", 8'h20, 64'd16);
    rd_chk("gap_cycles", 8'h30, 64'(t_last - ts));
    rd_chk("gap_first", 8'h38, NoErr);
    rd_chk("gap_status", 8'h08, 64'b010);

    // Zero length
    axi_write(8'h10, 64'd0);
    axi_write(8'h00, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge aclk); if (s_tready) seen = 1'b1; end
    check_eq("zero_tready", 64'(seen), 64'd0);
    rd_chk("zero_status", 8'h08, 64'b010);
    rd_chk("zero_rx", 8'h20, 64'd0);

    // Start ignored in RUN, config write deferred, lane values wrap
    seed = 64'hFFFF_FFFF_FFFF_FFFE;
    axi_write(8'h18, seed);
    axi_write(8'h10, 64'd3);
    axi_write(8'h00, 64'd1);
    send_beat(seed, 0, 1'b0, 0, '1, -1);
    send_beat(seed, 1, 1'b0, 0, {{(DataBits/8-1){1'b1}}, 1'b0}, -1);
    axi_write(8'h00, 64'd3);
    axi_write(8'h10, 64'd5);
    rd_chk("ign_status", 8'h08, 64'b101);
    rd_chk("ign_rx", 8'h20, 64'd2);
    send_beat(seed, 2, 1'b1, 0, '1, -1);
    rd_chk("ign_done", 8'h08, 64'b110);
    rd_chk("ign_rx3", 8'h20, 64'd3);
    rd_chk("ign_first", 8'h38, 64'd1);
    rd_chk("ign_exp", 8'h10, 64'd5);

    // Restart from DONE clears counters
    axi_write(8'h00, 64'd1);
    rd_chk("rs_rx", 8'h20, 64'd0);
    rd_chk("rs_err", 8'h28, 64'd0);
    rd_chk("rs_first", 8'h38, NoErr);
    rd_chk("rs_status", 8'h08, 64'b001);
    for (int i = 0; i < 5; i++) send_beat(seed, i, i == 4, 0, '1, -1);
    rd_chk("rs_rx5", 8'h20, 64'd5);
    rd_chk("rs_err5", 8'h28, 64'd0);

    // Clear counters in DONE
    axi_write(8'h00, 64'd2);
    rd_chk("clr_rx", 8'h20, 64'd0);
    rd_chk("clr_cycles", 8'h30, 64'd0);
    rd_chk("clr_status", 8'h08, 64'b010);

    // Reset mid-run
    axi_write(8'h18, 64'h55);
    axi_write(8'h10, 64'd8);
    axi_write(8'h00, 64'd1);
    for (int i = 0; i < 3; i++) send_beat(64'h55, i, 1'b0, 0, '1, -1);
    @(negedge aclk) areset = 1'b1;
    #1;
    check_eq("mid_tready", 64'(s_tready), 64'd0);
    @(posedge aclk);
    @(negedge aclk) areset = 1'b0;
    #1;
    check_eq("mid_bvalid", 64'(axi_ctrl.bvalid), 64'd0);
    check_eq("mid_rvalid", 64'(axi_ctrl.rvalid), 64'd0);
    check_reset_regs("mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
